lcd_bus_arbiter: RTL

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

---
 rtl/lcd_bus_arbiter_if.sv | 29 ++
 rtl/lcd_bus_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/lcd_bus_arbiter_if.sv
// Requester and HD44780 pins of the two-requester LCD bus arbiter.
// The master side is the requester pair and the slave side is the arbiter.
interface lcd_bus_arbiter_if;
   logic       req0;
   logic       req1;
   logic       rs0;
   logic       rs1;
   logic [7:0] byte0;
   logic [7:0] byte1;
   logic       last0;
   logic       last1;
   logic       ack0;
   logic       ack1;
   logic       en;
   logic       rs;
   logic [3:0] data;
   logic       busy;
   logic [1:0] grant;

   modport master (
      output req0, req1, rs0, rs1, byte0, byte1, last0, last1,
      input  ack0, ack1, en, rs, data, busy, grant
   );

   modport slave (
      input  req0, req1, rs0, rs1, byte0, byte1, last0, last1,
      output ack0, ack1, en, rs, data, busy, grant
   );
endinterface

// File: rtl/lcd_bus_arbiter.sv
// Round-robin arbiter with transaction locking that shares one HD44780 4-bit bus.
// Each captured byte goes out as two enable strobes, high nibble first, then a settle wait.
module lcd_bus_arbiter #(
   parameter int unsigned SHORT_WAIT = 1,
   parameter int unsigned LONG_WAIT  = 2
) (
   input  logic            clk,
   input  logic            reset,
   lcd_bus_arbiter_if.slave bus
);

   localparam logic [7:0] SHORT_M1 = 8'(SHORT_WAIT - 1);
   localparam logic [7:0] LONG_M1  = 8'(LONG_WAIT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StHiEn,
      StHiGap,
      StLoEn,
      StLoGap,
      StWait
   } state_e;

   state_e     state_q, state_d;
   logic       rs_q, rs_d;
   logic [7:0] byte_q, byte_d;
   logic       prev_q, prev_d;
   logic       lock_q, lock_d;
   logic [1:0] grant_q, grant_d;
   logic       ack0_q, ack0_d;
   logic       ack1_q, ack1_d;
   logic [7:0] cnt_q, cnt_d;

   logic       req_any;
   logic       winner;
   logic       long_cmd;

   // A lock pins the choice to the last served requester; otherwise alternate on contention.
   always_comb begin
      req_any = 1'b0;
      winner  = 1'b0;
      if (lock_q) begin
         req_any = prev_q ? bus.req1 : bus.req0;
         winner  = prev_q;
      end else if (bus.req0 && bus.req1) begin
         req_any = 1'b1;
         winner  = ~prev_q;
      end else if (bus.req0) begin
         req_any = 1'b1;
         winner  = 1'b0;
      end else if (bus.req1) begin
         req_any = 1'b1;
         winner  = 1'b1;
      end
   end

   // Clear display and return home need the long settle time.
   assign long_cmd = !rs_q && ((byte_q == 8'h01) || (byte_q == 8'h02) || (byte_q == 8'h03));

   always_comb begin
      state_d = state_q;
      rs_d    = rs_q;
      byte_d  = byte_q;
      prev_d  = prev_q;
      lock_d  = lock_q;
      grant_d = grant_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (req_any) begin
               state_d = StHiEn;
               rs_d    = winner ? bus.rs1 : bus.rs0;
               byte_d  = winner ? bus.byte1 : bus.byte0;
               lock_d  = winner ? ~bus.last1 : ~bus.last0;
               prev_d  = winner;
               grant_d = winner ? 2'b10 : 2'b01;
               ack0_d  = ~winner;
               ack1_d  = winner;
            end
         end
         StHiEn:  state_d = StHiGap;
         StHiGap: state_d = StLoEn;
         StLoEn:  state_d = StLoGap;
         StLoGap: begin
            state_d = StWait;
            cnt_d   = long_cmd ? LONG_M1 : SHORT_M1;
         end
         StWait: begin
            if (cnt_q == 8'd0) begin
               state_d = StIdle;
               if (!lock_q) begin
                  grant_d = 2'b00;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         rs_q    <= 1'b0;
         byte_q  <= 8'h00;
         prev_q  <= 1'b1;
         lock_q  <= 1'b0;
         grant_q <= 2'b00;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         rs_q    <= rs_d;
         byte_q  <= byte_d;
         prev_q  <= prev_d;
         lock_q  <= lock_d;
         grant_q <= grant_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.en    = (state_q == StHiEn) || (state_q == StLoEn);
   assign bus.rs    = rs_q;
   assign bus.data  = ((state_q == StHiEn) || (state_q == StHiGap)) ? byte_q[7:4] : byte_q[3:0];
   assign bus.busy  = (state_q != StIdle);
   assign bus.grant = grant_q;
   assign bus.ack0  = ack0_q;
   assign bus.ack1  = ack1_q;

   ack_exclusive: assert property (@(posedge clk) disable iff (!reset) !(bus.ack0 && bus.ack1));
   en_one_cycle:  assert property (@(posedge clk) disable iff (!reset) bus.en |=> !bus.en);

endmodule
